// File: rtl/ddr_dq_lpbk_prbs_chk_pkg.sv
// Shared types and constants for the DQ/CA lane loopback pattern checkers.
package ddr_dq_lpbk_prbs_chk_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_FIXED  = 2'd3
  } lpbk_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_CHECK = 2'd2
  } lpbk_state_e;

  localparam int LFSR_W = 15;

  // Fibonacci taps: x^7+x^6+1 and x^15+x^14+1, output taken from the MSB
  localparam int PRBS7_MSB  = 6;
  localparam int PRBS7_TAP  = 5;
  localparam int PRBS15_MSB = 14;
  localparam int PRBS15_TAP = 13;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/ddr_lpbk_lfsr.sv
// Loadable pattern source (PRBS7/PRBS15/toggle/fixed); bit_nxt is the bit held after the next edge.
module ddr_lpbk_lfsr
  import ddr_dq_lpbk_prbs_chk_pkg::*;
#(
  parameter int W = LFSR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  lpbk_mode_e   mode,
  input  logic [W-1:0] seed,
  input  logic         fixed_val,
  output logic         bit_nxt
);

  localparam logic [W-1:0] ONE = W'(1);

  lpbk_mode_e   mode_q, mode_d;
  logic [W-1:0] state_q, state_d;

  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    if (load) begin
      mode_d = mode;
      unique case (mode)
        MODE_PRBS7:  state_d = (seed[PRBS7_MSB:0] == '0) ? ONE : W'(seed[PRBS7_MSB:0]);
        MODE_PRBS15: state_d = (seed[PRBS15_MSB:0] == '0) ? ONE : W'(seed[PRBS15_MSB:0]);
        MODE_TOGGLE: state_d = ONE;
        default:     state_d = W'(fixed_val);
      endcase
    end else if (en) begin
      unique case (mode_q)
        MODE_PRBS7:  state_d = W'({state_q[PRBS7_MSB-1:0],
                                   state_q[PRBS7_MSB] ^ state_q[PRBS7_TAP]});
        MODE_PRBS15: state_d = W'({state_q[PRBS15_MSB-1:0],
                                   state_q[PRBS15_MSB] ^ state_q[PRBS15_TAP]});
        MODE_TOGGLE: state_d = state_q ^ ONE;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_nxt = state_d[0];
    unique case (mode_d)
      MODE_PRBS7:  bit_nxt = state_d[PRBS7_MSB];
      MODE_PRBS15: bit_nxt = state_d[PRBS15_MSB];
      default:     bit_nxt = state_d[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_PRBS7;
      state_q <= ONE;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/ddr_dq_lpbk_prbs_chk.sv
// DQ lane loopback pattern generator/checker: drives o_d_n/o_oe, compares the
// synchronized loopback return against a delayed TX history and counts errors.
module ddr_dq_lpbk_prbs_chk
  import ddr_dq_lpbk_prbs_chk_pkg::*;
#(
  parameter int LAT_W = 4,
  parameter int ERR_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [1:0]       i_mode,
  input  logic             i_fixed_val,
  input  logic [14:0]      i_seed,
  input  logic [LAT_W-1:0] i_lat,
  input  logic             i_d_lpbk,
  output logic             o_d_n,
  output logic             o_oe,
  output logic             o_busy,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_err,
  output logic             o_pass
);

  localparam int             HIST_D    = (1 << LAT_W) + SYNC_DEPTH;
  localparam logic [LAT_W:0] ALIGN_ONE = (LAT_W+1)'(1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  lpbk_state_e           state_q, state_d;
  logic [LAT_W:0]        align_q, align_d;
  logic [LAT_W-1:0]      lat_q;
  logic                  active_q;
  logic                  d_n_q;
  logic                  start_acc;
  logic                  tx_nxt;
  logic [HIST_D-1:0]     hist_q;
  logic [SYNC_DEPTH-1:0] rx_sync_p0;
  logic                  rx_s;
  logic [LAT_W:0]        exp_idx;
  logic                  chk;
  logic                  miss;
  logic [ERR_W-1:0]      err_cnt_q;
  logic                  err_q;
  logic                  pass_q;

  assign start_acc = (state_q == ST_IDLE) && i_start;

  always_comb begin
    state_d = state_q;
    align_d = align_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ALIGN;
          align_d = {1'b0, i_lat} + (LAT_W+1)'(SYNC_DEPTH);
        end
      end
      ST_ALIGN: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else begin
          align_d = align_q - ALIGN_ONE;
          if (align_q == ALIGN_ONE) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (i_stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ddr_lpbk_lfsr #(
    .W (LFSR_W)
  ) u_lfsr (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load      (start_acc),
    .en        (active_q),
    .mode      (lpbk_mode_e'(i_mode)),
    .seed      (i_seed),
    .fixed_val (i_fixed_val),
    .bit_nxt   (tx_nxt)
  );

  // TX stage: state, registered pad data/enable, configuration capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      align_q  <= '0;
      lat_q    <= '0;
      active_q <= 1'b0;
      d_n_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      align_q  <= align_d;
      active_q <= (state_d != ST_IDLE);
      d_n_q    <= (state_d != ST_IDLE) ? ~tx_nxt : 1'b1;
      if (start_acc) lat_q <= i_lat;
    end
  end

  // History stage: hist_q[j] holds the TX bit driven j+1 cycles ago
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_q     <= '0;
      rx_sync_p0 <= '0;
    end else begin
      if (active_q) hist_q <= {hist_q[HIST_D-2:0], ~d_n_q};
      rx_sync_p0 <= {rx_sync_p0[SYNC_DEPTH-2:0], i_d_lpbk};
    end
  end

  assign rx_s    = rx_sync_p0[SYNC_DEPTH-1];
  assign exp_idx = {1'b0, lat_q} + (LAT_W+1)'(SYNC_DEPTH - 1);
  assign chk     = (state_q == ST_CHECK);
  assign miss    = chk && (rx_s != hist_q[exp_idx]);

  // Compare stage: the stop-cycle sample counts toward the pass verdict
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else if (start_acc) begin
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      if (miss) begin
        err_cnt_q <= sat_inc(err_cnt_q);
        err_q     <= 1'b1;
      end
      if (chk && i_stop) pass_q <= ~(err_q | miss);
    end
  end

  assign o_d_n     = d_n_q;
  assign o_oe      = active_q;
  assign o_busy    = active_q;
  assign o_err_cnt = err_cnt_q;
  assign o_err     = err_q;
  assign o_pass    = pass_q;

endmodule
